rom_dl_bridge: RTL and testbench

//  Sits between data_io (ioctl byte stream) and the sdram download ports.
//  - Buffers downloaded bytes and converts them into toggle req/ack writes on port1 (all ROM) and port2 (sprite ROM, 32-bit interleave).
//  - Signals ROM-loaded once every buffered write has been acknowledged.
//  - Replaces the open-loop toggle logic in the core top level; ack is honoured, never ignored.

---
 rtl/rom_dl_pkg.sv | 23 ++
 rtl/dl_fifo.sv | 49 ++++
 rtl/rom_dl_bridge.sv | 153 +++++++++++++++
 tb/tb_rom_dl_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and defaults for the ROM download bridge.
package rom_dl_pkg;

   localparam logic [24:0] SP_BASE_DEF = 25'h10000;
   localparam logic [24:0] SP_SIZE_DEF = 25'h0C000;

   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } dl_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } dl_state_t;

   function automatic logic in_region(input logic [24:0] a,
                                      input logic [24:0] base,
                                      input logic [24:0] size);
      return (a >= base) && (a < (base + size));
   endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO of download entries; a pop frees a slot for a push
// arriving in the same cycle even when full.
module dl_fifo
   import rom_dl_pkg::*;
#(
   parameter int AW = 2
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      push,
   input  dl_entry_t push_data,
   input  logic      pop,
   output dl_entry_t pop_data,
   output logic      full,
   output logic      empty
);

   localparam int DEPTH = 1 << AW;

   dl_entry_t       mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/rom_dl_bridge.sv
// Buffers ioctl download bytes and commits them to the sdram ports with
// toggle req/ack handshakes. Optional DL_CHECKSUM_EN adds the dl_sum output.
//
//   state | meaning
//   IDLE  | no write outstanding; pops the next buffered entry if any
//   WAIT  | write issued; holding a/ds/d until every issued port acks
module rom_dl_bridge
   import rom_dl_pkg::*;
#(
   parameter logic [24:0] SP_BASE = SP_BASE_DEF,
   parameter logic [24:0] SP_SIZE = SP_SIZE_DEF,
   parameter int          FIFO_AW = 2
) (
   input  logic        clk_sd,
   input  logic        reset_n,
   input  logic        ioctl_downl,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic        port_we,
   output logic        rom_loaded,
   output logic        dl_overflow
`ifdef DL_CHECKSUM_EN
   ,
   output logic [15:0] dl_sum
`endif
);

   dl_state_t   state;
   dl_state_t   state_next;
   dl_entry_t   push_ent;
   dl_entry_t   pop_ent;
   logic        wr_q;
   logic        downl_q;
   logic        downl_rise;
   logic        seen_dl;
   logic        p2_pend;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic        hit;
   logic        p1_done;
   logic        p2_done;
   logic [23:0] off;

   assign downl_rise = ioctl_downl & ~downl_q;
   assign push       = ioctl_wr & ~wr_q & ioctl_downl;
   assign push_ent   = '{addr: ioctl_addr, data: ioctl_dout};
   assign hit        = in_region(pop_ent.addr, SP_BASE, SP_SIZE);
   // Offset only needs 24 bits; the region test above uses the full address.
   assign off        = pop_ent.addr[23:0] - SP_BASE[23:0];
   assign p1_done    = (port1_ack == port1_req);
   assign p2_done    = ~p2_pend | (port2_ack == port2_req);
   assign port_we    = ioctl_downl;

   dl_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk       (clk_sd),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .pop_data  (pop_ent),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (p1_done && p2_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sd) begin
      if (!reset_n) begin
         state       <= IDLE;
         wr_q        <= 1'b0;
         downl_q     <= 1'b0;
         seen_dl     <= 1'b0;
         p2_pend     <= 1'b0;
         port1_req   <= port1_ack;
         port2_req   <= port2_ack;
         port1_a     <= '0;
         port1_ds    <= '0;
         port1_d     <= '0;
         port2_a     <= '0;
         port2_ds    <= '0;
         port2_d     <= '0;
         rom_loaded  <= 1'b0;
         dl_overflow <= 1'b0;
      end else begin
         state   <= state_next;
         wr_q    <= ioctl_wr;
         downl_q <= ioctl_downl;
         if (ioctl_downl) seen_dl <= 1'b1;

         if (downl_rise)            dl_overflow <= 1'b0;
         if (push && full && !pop)  dl_overflow <= 1'b1;

         if (downl_rise)
            rom_loaded <= 1'b0;
         else if (!ioctl_downl && seen_dl && empty && state == IDLE)
            rom_loaded <= 1'b1;

         if (pop) begin
            port1_a   <= pop_ent.addr[23:1];
            port1_ds  <= {pop_ent.addr[0], ~pop_ent.addr[0]};
            port1_d   <= {pop_ent.data, pop_ent.data};
            port1_req <= ~port1_req;
            p2_pend   <= hit;
            if (hit) begin
               port2_a   <= {off[23:16], off[13:0], off[15]};
               port2_ds  <= {off[14], ~off[14]};
               port2_d   <= {pop_ent.data, pop_ent.data};
               port2_req <= ~port2_req;
            end
         end
      end
   end

`ifdef DL_CHECKSUM_EN
   always_ff @(posedge clk_sd) begin
      if (!reset_n)
         dl_sum <= '0;
      else if (downl_rise)
         dl_sum <= pop ? {8'h00, pop_ent.data} : 16'h0000;
      else if (pop)
         dl_sum <= dl_sum + {8'h00, pop_ent.data};
   end
`endif

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed self-checking bench for rom_dl_bridge (define DL_CHECKSUM_EN to cover dl_sum).
module tb_rom_dl_bridge;

   logic        clk_sd = 1'b0;
   logic        reset_n;
   logic        ioctl_downl;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        port1_req;
   logic        port1_ack;
   logic [22:0] port1_a;
   logic [1:0]  port1_ds;
   logic [15:0] port1_d;
   logic        port2_req;
   logic        port2_ack;
   logic [22:0] port2_a;
   logic [1:0]  port2_ds;
   logic [15:0] port2_d;
   logic        port_we;
   logic        rom_loaded;
   logic        dl_overflow;
`ifdef DL_CHECKSUM_EN
   logic [15:0] dl_sum;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk_sd = ~clk_sd;

   rom_dl_bridge dut (
      .clk_sd      (clk_sd),
      .reset_n     (reset_n),
      .ioctl_downl (ioctl_downl),
      .ioctl_wr    (ioctl_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .port1_req   (port1_req),
      .port1_ack   (port1_ack),
      .port1_a     (port1_a),
      .port1_ds    (port1_ds),
      .port1_d     (port1_d),
      .port2_req   (port2_req),
      .port2_ack   (port2_ack),
      .port2_a     (port2_a),
      .port2_ds    (port2_ds),
      .port2_d     (port2_d),
      .port_we     (port_we),
      .rom_loaded  (rom_loaded),
      .dl_overflow (dl_overflow)
`ifdef DL_CHECKSUM_EN
      ,
      .dl_sum      (dl_sum)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sd);
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sd);
      ioctl_wr   = 1'b0;
      @(negedge clk_sd);
   endtask

   task automatic wait_req1(input string tag);
      int i = 0;
      while (port1_req === port1_ack && i < 12) begin
         @(negedge clk_sd);
         i++;
      end
      chk(tag, 32'(port1_req ^ port1_ack), 32'd1);
   endtask

   // One byte end to end, with the sdram acking a few cycles after the request.
   task automatic xfer(input string tag, input logic [24:0] a, input logic [7:0] d,
                       input logic [22:0] e1a, input logic [1:0] e1ds,
                       input logic p2, input logic [22:0] e2a, input logic [1:0] e2ds);
      send(a, d);
      wait_req1({tag, "_req1"});
      chk({tag, "_p1a"},  32'(port1_a),  32'(e1a));
      chk({tag, "_p1ds"}, 32'(port1_ds), 32'(e1ds));
      chk({tag, "_p1d"},  32'(port1_d),  32'({d, d}));
      chk({tag, "_req2"}, 32'(port2_req ^ port2_ack), 32'(p2));
      if (p2) begin
         chk({tag, "_p2a"},  32'(port2_a),  32'(e2a));
         chk({tag, "_p2ds"}, 32'(port2_ds), 32'(e2ds));
         chk({tag, "_p2d"},  32'(port2_d),  32'({d, d}));
      end
      tick(3);
      port1_ack = port1_req;
      port2_ack = port2_req;
      tick(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;

      reset_n     = 1'b0;
      ioctl_downl = 1'b0;
      ioctl_wr    = 1'b0;
      ioctl_addr  = '0;
      ioctl_dout  = '0;
      port1_ack   = 1'b1;
      port2_ack   = 1'b0;
      tick(3);
      chk("rst_req1",   32'(port1_req),   32'd1);
      chk("rst_req2",   32'(port2_req),   32'd0);
      chk("rst_p1a",    32'(port1_a),     32'd0);
      chk("rst_loaded", 32'(rom_loaded),  32'd0);
      chk("rst_ovf",    32'(dl_overflow), 32'd0);
      reset_n = 1'b1;
      tick(4);
      chk("no_dl_loaded", 32'(rom_loaded), 32'd0);

      // Strobe without download is ignored
      send(25'h00007, 8'h77);
      tick(3);
      chk("nodl_req1", 32'(port1_req ^ port1_ack), 32'd0);

      ioctl_downl = 1'b1;
      tick(1);
      chk("port_we", 32'(port_we), 32'd1);

      // Single main-ROM byte; outputs must hold while waiting for ack
      send(25'h00003, 8'hA5);
      wait_req1("b1_req1");
      chk("b1_p1a",  32'(port1_a),  32'd1);
      chk("b1_p1ds", 32'(port1_ds), 32'h2);
      chk("b1_p1d",  32'(port1_d),  32'hA5A5);
      chk("b1_req2", 32'(port2_req ^ port2_ack), 32'd0);
      tick(3);
      chk("b1_hold", 32'(port1_d), 32'hA5A5);
      port1_ack = port1_req;
      tick(3);
      chk("b1_single", 32'(port1_req ^ port1_ack), 32'd0);

      // Sprite byte: both ports issued; WAIT blocks until port2 acks too
      send(25'h14001, 8'h5A);
      wait_req1("sp_req1");
      chk("sp_p1a",  32'(port1_a),  32'h00A000);
      chk("sp_p1ds", 32'(port1_ds), 32'h2);
      chk("sp_req2", 32'(port2_req ^ port2_ack), 32'd1);
      chk("sp_p2a",  32'(port2_a),  32'h000002);
      chk("sp_p2ds", 32'(port2_ds), 32'h2);
      chk("sp_p2d",  32'(port2_d),  32'h5A5A);
      tick(2);
      port1_ack = port1_req;
      send(25'h00010, 8'h22);
      tick(3);
      chk("sp_wait_req1", 32'(port1_req ^ port1_ack), 32'd0);
      chk("sp_wait_d",    32'(port1_d), 32'h5A5A);
      port2_ack = port2_req;
      wait_req1("sp_next_req1");
      chk("sp_next_d",    32'(port1_d),  32'h2222);
      chk("sp_next_a",    32'(port1_a),  32'h8);
      chk("sp_next_ds",   32'(port1_ds), 32'h1);
      chk("sp_next_req2", 32'(port2_req ^ port2_ack), 32'd0);
      tick(2);
      port1_ack = port1_req;
      tick(2);

      // Region boundaries
      xfer("below", 25'h00FFFF, 8'h31, 23'h007FFF, 2'b10, 1'b0, 23'h0, 2'b00);
      xfer("first", 25'h010000, 8'h33, 23'h008000, 2'b01, 1'b1, 23'h000000, 2'b01);
      xfer("last",  25'h01BFFF, 8'h32, 23'h00DFFF, 2'b10, 1'b1, 23'h007FFF, 2'b01);
      xfer("end",   25'h01C000, 8'h34, 23'h00E000, 2'b01, 1'b0, 23'h0, 2'b00);
      xfer("bit24", 25'h1010000, 8'h35, 23'h008000, 2'b01, 1'b0, 23'h0, 2'b00);

      // Overflow: first byte goes straight out, next four fill the FIFO, sixth dropped
      for (int k = 0; k < 6; k++) begin
         b = 8'(8'h11 * (k + 1));
         send(25'(32'h20 + k), b);
      end
      chk("ovf_flag", 32'(dl_overflow), 32'd1);
      chk("ovf_d0",   32'(port1_d), 32'h1111);
      tick(8);
      for (int k = 1; k < 5; k++) begin
         b = 8'(8'h11 * (k + 1));
         port1_ack = port1_req;
         tick(1);
         wait_req1("ovf_req");
         chk("ovf_order", 32'(port1_d), 32'({b, b}));
      end
      tick(2);
      port1_ack = port1_req;
      tick(4);
      chk("ovf_drop",   32'(port1_req ^ port1_ack), 32'd0);
      chk("ovf_sticky", 32'(dl_overflow), 32'd1);
      ioctl_downl = 1'b0;
      tick(3);
      chk("loaded_idle", 32'(rom_loaded), 32'd1);
      ioctl_downl = 1'b1;
      tick(1);
      chk("ovf_clear",    32'(dl_overflow), 32'd0);
      chk("loaded_clear", 32'(rom_loaded),  32'd0);

      // Download ends with entries still pending
      send(25'h00100, 8'hC1);
      send(25'h00101, 8'hC2);
      send(25'h00102, 8'hC3);
      ioctl_downl = 1'b0;
      tick(5);
      chk("pend_loaded0", 32'(rom_loaded), 32'd0);
      port1_ack = port1_req;
      tick(1);
      wait_req1("pend_req_b");
      chk("pend_d_b", 32'(port1_d), 32'hC2C2);
      port1_ack = port1_req;
      tick(1);
      wait_req1("pend_req_c");
      chk("pend_d_c", 32'(port1_d), 32'hC3C3);
      tick(3);
      chk("pend_loaded1", 32'(rom_loaded), 32'd0);
      port1_ack = port1_req;
      tick(2);
      chk("pend_loaded2", 32'(rom_loaded), 32'd1);

      // Reset during WAIT with one more entry buffered
      ioctl_downl = 1'b1;
      tick(1);
      send(25'h00200, 8'hD1);
      send(25'h00201, 8'hD2);
      chk("rw_req1", 32'(port1_req ^ port1_ack), 32'd1);
      reset_n = 1'b0;
      tick(2);
      chk("rw_rst_req1", 32'(port1_req ^ port1_ack), 32'd0);
      chk("rw_rst_req2", 32'(port2_req ^ port2_ack), 32'd0);
      reset_n = 1'b1;
      tick(6);
      chk("rw_flush", 32'(port1_req ^ port1_ack), 32'd0);
      chk("rw_p1d",   32'(port1_d), 32'd0);

`ifdef DL_CHECKSUM_EN
      ioctl_downl = 1'b0;
      tick(2);
      ioctl_downl = 1'b1;
      tick(1);
      chk("sum_start", 32'(dl_sum), 32'd0);
      xfer("s1", 25'h00300, 8'hFF, 23'h000180, 2'b01, 1'b0, 23'h0, 2'b00);
      xfer("s2", 25'h00301, 8'h02, 23'h000180, 2'b10, 1'b0, 23'h0, 2'b00);
      xfer("s3", 25'h00302, 8'h01, 23'h000181, 2'b01, 1'b0, 23'h0, 2'b00);
      chk("sum_value", 32'(dl_sum), 32'h0102);
      ioctl_downl = 1'b0;
      tick(2);
      ioctl_downl = 1'b1;
      tick(1);
      chk("sum_clear", 32'(dl_sum), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
